// File: rtl/uart_core_cfg.sv
// Parametrised full-duplex UART: configurable data width, parity and stop bits,
// shared 16x tick generator, 2-flop rx synchroniser and independent TX/RX FSMs.
module uart_core_cfg #(
   parameter int unsigned CLK_FREQ  = 1000000,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic [DATA_BITS-1:0] dintx,
   input  logic                 newd,
   output logic                 tx,
   output logic [DATA_BITS-1:0] doutrx,
   output logic                 donetx,
   output logic                 donerx,
   output logic                 txbusy,
   output logic                 perr,
   output logic                 ferr
);

   localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * 16);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic [4:0]    STOP_LAST = 5'(STOP_BITS * 16 - 1);

   // ---------------- tick generator ----------------
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;

   always_comb begin
      tick       = (tick_cnt_q == DIV_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tick_cnt_q <= '0;
      else      tick_cnt_q <= tick_cnt_d;
   end

   // ---------------- rx synchroniser ----------------
   logic [1:0] rx_sync_q, rx_sync_d;
   logic       rx_s;

   always_comb rx_sync_d = {rx_sync_q[0], rx};
   assign rx_s = rx_sync_q[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_sync_q <= 2'b11;
      else      rx_sync_q <= rx_sync_d;
   end

   // ---------------- transmitter ----------------
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

   tx_state_e            tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
   logic [4:0]           tx_tcnt_q, tx_tcnt_d;
   logic [2:0]           tx_bit_q, tx_bit_d;
   logic                 tx_armed_q, tx_armed_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_q, tx_d;
   logic                 txbusy_q, txbusy_d;
   logic                 donetx_q, donetx_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_data_d  = tx_data_q;
      tx_tcnt_d  = tx_tcnt_q;
      tx_bit_d   = tx_bit_q;
      tx_armed_d = tx_armed_q;
      tx_par_d   = tx_par_q;
      tx_d       = tx_q;
      txbusy_d   = txbusy_q;
      donetx_d   = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (newd) begin
               tx_data_d  = dintx;
               tx_par_d   = (PARITY == 1) ? ~^dintx : ^dintx;
               txbusy_d   = 1'b1;
               tx_armed_d = 1'b0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            // the first tick after the request aligns the start bit to the tick grid
            if (tick) begin
               if (!tx_armed_q) begin
                  tx_armed_d = 1'b1;
                  tx_d       = 1'b0;
                  tx_tcnt_d  = '0;
               end else if (tx_tcnt_q == 5'd15) begin
                  tx_tcnt_d  = '0;
                  tx_bit_d   = '0;
                  tx_d       = tx_data_q[0];
                  tx_state_d = TX_DATA;
               end else begin
                  tx_tcnt_d = tx_tcnt_q + 5'd1;
               end
            end
         end
         TX_DATA: begin
            if (tick) begin
               if (tx_tcnt_q == 5'd15) begin
                  tx_tcnt_d = '0;
                  if (tx_bit_q == LAST_BIT) begin
                     if (PARITY != 0) begin
                        tx_d       = tx_par_q;
                        tx_state_d = TX_PAR;
                     end else begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                     end
                  end else begin
                     tx_bit_d  = tx_bit_q + 3'd1;
                     tx_data_d = {1'b0, tx_data_q[DATA_BITS-1:1]};
                     tx_d      = tx_data_q[1];
                  end
               end else begin
                  tx_tcnt_d = tx_tcnt_q + 5'd1;
               end
            end
         end
         TX_PAR: begin
            if (tick) begin
               if (tx_tcnt_q == 5'd15) begin
                  tx_tcnt_d  = '0;
                  tx_d       = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_tcnt_d = tx_tcnt_q + 5'd1;
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (tx_tcnt_q == STOP_LAST) begin
                  tx_tcnt_d  = '0;
                  donetx_d   = 1'b1;
                  txbusy_d   = 1'b0;
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_tcnt_d = tx_tcnt_q + 5'd1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= TX_IDLE;
         tx_data_q  <= '0;
         tx_tcnt_q  <= '0;
         tx_bit_q   <= '0;
         tx_armed_q <= 1'b0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         txbusy_q   <= 1'b0;
         donetx_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_data_q  <= tx_data_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_armed_q <= tx_armed_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
         txbusy_q   <= txbusy_d;
         donetx_q   <= donetx_d;
      end
   end

   // ---------------- receiver ----------------
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_e;

   rx_state_e            rx_state_q, rx_state_d;
   logic [3:0]           rx_tcnt_q, rx_tcnt_d;
   logic [2:0]           rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_par_q, rx_par_d;
   logic [DATA_BITS-1:0] doutrx_q, doutrx_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 donerx_q, donerx_d;
   logic                 rx_par_exp;

   always_comb begin
      rx_par_exp = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;
      rx_state_d = rx_state_q;
      rx_tcnt_d  = rx_tcnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      doutrx_d   = doutrx_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      donerx_d   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_tcnt_d  = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (tick) begin
               if (rx_tcnt_q == 4'd7) begin
                  rx_tcnt_d = '0;
                  if (rx_s) begin
                     rx_state_d = RX_IDLE;
                  end else begin
                     rx_bit_d   = '0;
                     rx_state_d = RX_DATA;
                  end
               end else begin
                  rx_tcnt_d = rx_tcnt_q + 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
               if (rx_tcnt_q == 4'd15) begin
                  rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                  if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
                  else                      rx_bit_d   = rx_bit_q + 3'd1;
               end
            end
         end
         RX_PAR: begin
            if (tick) begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
               if (rx_tcnt_q == 4'd15) begin
                  rx_par_d   = rx_s;
                  rx_state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            // a low stop bit holds the receiver in RX_BREAK until the line idles
            if (tick) begin
               rx_tcnt_d = rx_tcnt_q + 4'd1;
               if (rx_tcnt_q == 4'd15) begin
                  doutrx_d   = rx_shift_q;
                  perr_d     = (PARITY != 0) && (rx_par_q != rx_par_exp);
                  ferr_d     = !rx_s;
                  donerx_d   = 1'b1;
                  rx_state_d = rx_s ? RX_IDLE : RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            if (rx_s) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_q <= RX_IDLE;
         rx_tcnt_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         doutrx_q   <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         donerx_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         doutrx_q   <= doutrx_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         donerx_q   <= donerx_d;
      end
   end

   assign tx     = tx_q;
   assign txbusy = txbusy_q;
   assign donetx = donetx_q;
   assign doutrx = doutrx_q;
   assign donerx = donerx_q;
   assign perr   = perr_q;
   assign ferr   = ferr_q;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg: 8N1 loopback table, 7E1 parity, two stop bits,
// framing error / break hold, glitch rejection and mid-frame reset.
module tb_uart_core_cfg;

   localparam int BIT = 96;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       loop_en, rx_drv, rx_par_drv, rx_idle;
   logic [7:0] dintx_m, dintx_s2;
   logic [6:0] dintx_p;
   logic       newd_m, newd_p, newd_s2;

   logic       tx_m, donetx_m, donerx_m, txbusy_m, perr_m, ferr_m, rx_m;
   logic [7:0] doutrx_m;
   logic       tx_p, donetx_p, donerx_p, txbusy_p, perr_p, ferr_p;
   logic [6:0] doutrx_p;
   logic       tx_s2, donetx_s2, donerx_s2, txbusy_s2, perr_s2, ferr_s2;
   logic [7:0] doutrx_s2;

   assign rx_m = loop_en ? tx_m : rx_drv;

   uart_core_cfg u_dut (
      .clk(clk), .rst(rst), .rx(rx_m), .dintx(dintx_m), .newd(newd_m), .tx(tx_m),
      .doutrx(doutrx_m), .donetx(donetx_m), .donerx(donerx_m), .txbusy(txbusy_m),
      .perr(perr_m), .ferr(ferr_m));

   uart_core_cfg #(.DATA_BITS(7), .PARITY(2)) u_par (
      .clk(clk), .rst(rst), .rx(rx_par_drv), .dintx(dintx_p), .newd(newd_p), .tx(tx_p),
      .doutrx(doutrx_p), .donetx(donetx_p), .donerx(donerx_p), .txbusy(txbusy_p),
      .perr(perr_p), .ferr(ferr_p));

   uart_core_cfg #(.STOP_BITS(2)) u_stop2 (
      .clk(clk), .rst(rst), .rx(rx_idle), .dintx(dintx_s2), .newd(newd_s2), .tx(tx_s2),
      .doutrx(doutrx_s2), .donetx(donetx_s2), .donerx(donerx_s2), .txbusy(txbusy_s2),
      .perr(perr_s2), .ferr(ferr_s2));

   // ---------------- event monitors ----------------
   int         cyc = 0;
   int         dtx_cnt[3] = '{0, 0, 0};
   int         dtx_cyc[3] = '{0, 0, 0};
   logic       busy_at_done[3];
   int         drx_cnt[2] = '{0, 0};
   logic [7:0] cap_data[2];
   logic       cap_perr[2];
   logic       cap_ferr[2];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (donetx_m)  begin dtx_cnt[0]++; dtx_cyc[0] = cyc; busy_at_done[0] = txbusy_m;  end
      if (donetx_p)  begin dtx_cnt[1]++; dtx_cyc[1] = cyc; busy_at_done[1] = txbusy_p;  end
      if (donetx_s2) begin dtx_cnt[2]++; dtx_cyc[2] = cyc; busy_at_done[2] = txbusy_s2; end
      if (donerx_m) begin drx_cnt[0]++; cap_data[0] = doutrx_m; cap_perr[0] = perr_m; cap_ferr[0] = ferr_m; end
      if (donerx_p) begin drx_cnt[1]++; cap_data[1] = {1'b0, doutrx_p}; cap_perr[1] = perr_p; cap_ferr[1] = ferr_p; end
   end

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_bit(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic check_range(input string nm, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   function automatic logic sel_tx(input int inst);
      case (inst)
         0:       return tx_m;
         1:       return tx_p;
         default: return tx_s2;
      endcase
   endfunction

   function automatic logic sel_busy(input int inst);
      case (inst)
         0:       return txbusy_m;
         1:       return txbusy_p;
         default: return txbusy_s2;
      endcase
   endfunction

   // Request one frame and check every line bit at mid-bit plus the donetx pulse.
   task automatic send_frame(input int inst, input logic [7:0] d, input logic [11:0] frame,
                             input int nbits, input string nm);
      int t;
      int c0;
      int d0;
      d0 = dtx_cnt[inst];
      @(negedge clk);
      case (inst)
         0:       begin dintx_m  = d;      newd_m  = 1'b1; end
         1:       begin dintx_p  = d[6:0]; newd_p  = 1'b1; end
         default: begin dintx_s2 = d;      newd_s2 = 1'b1; end
      endcase
      c0 = cyc;
      @(negedge clk);
      newd_m = 1'b0; newd_p = 1'b0; newd_s2 = 1'b0;
      check_bit({nm, " busy after newd"}, sel_busy(inst), 1'b1);
      t = 0;
      while (sel_tx(inst) !== 1'b0 && t < 200) begin @(negedge clk); t++; end
      check_bit({nm, " start bit seen"}, t < 200, 1'b1);
      if (t >= 200) return;
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         check_bit($sformatf("%s line bit %0d", nm, i), sel_tx(inst), frame[i]);
         check_bit($sformatf("%s busy bit %0d", nm, i), sel_busy(inst), 1'b1);
         if (i < nbits - 1) repeat (BIT) @(negedge clk);
      end
      t = 0;
      while (dtx_cnt[inst] == d0 && t < 400) begin @(negedge clk); t++; end
      repeat (20) @(negedge clk);
      check_val({nm, " donetx pulses"}, 32'(dtx_cnt[inst] - d0), 32'd1);
      check_range({nm, " donetx latency"}, dtx_cyc[inst] - c0, nbits * BIT - BIT, nbits * BIT + BIT);
      check_bit({nm, " busy at donetx"}, busy_at_done[inst], 1'b0);
   endtask

   // Drive a bit pattern (index 0 first) onto an rx input, BIT cycles per bit.
   task automatic drive_rx(input int inst, input logic [11:0] bits, input int n, input logic last);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (inst == 0) rx_drv = bits[i];
         else           rx_par_drv = bits[i];
         repeat (BIT - 1) @(negedge clk);
      end
      @(negedge clk);
      if (inst == 0) rx_drv = last;
      else           rx_par_drv = last;
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [11:0] frame;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int t;
      int n;

      // 8N1 line image: {stop, data, start}, bit 0 transmitted first
      vecs[0] = '{8'hA5, 12'h34A};
      vecs[1] = '{8'h00, 12'h200};
      vecs[2] = '{8'hFF, 12'h3FE};
      vecs[3] = '{8'h3C, 12'h278};
      vecs[4] = '{8'h81, 12'h302};
      vecs[5] = '{8'h5A, 12'h2B4};
      vecs[6] = '{8'hC3, 12'h386};
      vecs[7] = '{8'h7E, 12'h2FC};
      vecs[8] = '{8'h01, 12'h202};
      vecs[9] = '{8'h80, 12'h300};

      rst = 1'b0; loop_en = 1'b1; rx_drv = 1'b1; rx_par_drv = 1'b1; rx_idle = 1'b1;
      newd_m = 1'b0; newd_p = 1'b0; newd_s2 = 1'b0;
      dintx_m = '0; dintx_p = '0; dintx_s2 = '0;

      repeat (3) @(negedge clk);
      check_bit("reset tx", tx_m, 1'b1);
      check_bit("reset txbusy", txbusy_m, 1'b0);
      check_bit("reset donetx", donetx_m, 1'b0);
      check_bit("reset donerx", donerx_m, 1'b0);
      check_val("reset doutrx", 32'(doutrx_m), 32'h0);
      check_bit("reset perr", perr_m, 1'b0);
      check_bit("reset ferr", ferr_m, 1'b0);
      check_bit("reset tx 7E1", tx_p, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      // loopback table
      for (int i = 0; i < 10; i++) begin
         r0 = drx_cnt[0];
         send_frame(0, vecs[i].data, vecs[i].frame, 10, $sformatf("loop%0d", i));
         check_val($sformatf("loop%0d donerx count", i), 32'(drx_cnt[0] - r0), 32'd1);
         check_val($sformatf("loop%0d doutrx", i), 32'(cap_data[0]), 32'(vecs[i].data));
         check_bit($sformatf("loop%0d perr", i), cap_perr[0], 1'b0);
         check_bit($sformatf("loop%0d ferr", i), cap_ferr[0], 1'b0);
      end

      // 7E1: 0x07 has three ones, so even parity bit is 1
      send_frame(1, 8'h07, 12'h30E, 10, "par7e1 tx");
      r0 = drx_cnt[1];
      drive_rx(1, 12'h30E, 10, 1'b1);
      repeat (BIT) @(negedge clk);
      check_val("par7e1 good count", 32'(drx_cnt[1] - r0), 32'd1);
      check_val("par7e1 good data", 32'(cap_data[1]), 32'h07);
      check_bit("par7e1 good perr", cap_perr[1], 1'b0);
      check_bit("par7e1 good ferr", cap_ferr[1], 1'b0);
      r0 = drx_cnt[1];
      drive_rx(1, 12'h20E, 10, 1'b1);
      repeat (BIT) @(negedge clk);
      check_val("par7e1 bad count", 32'(drx_cnt[1] - r0), 32'd1);
      check_val("par7e1 bad data", 32'(cap_data[1]), 32'h07);
      check_bit("par7e1 bad perr", cap_perr[1], 1'b1);
      check_bit("par7e1 bad ferr", cap_ferr[1], 1'b0);

      // two stop bits: line high 192 cycles from stop start to donetx
      @(negedge clk);
      dintx_s2 = 8'h00; newd_s2 = 1'b1;
      @(negedge clk);
      newd_s2 = 1'b0;
      t = 0;
      while (tx_s2 !== 1'b0 && t < 200) begin @(negedge clk); t++; end
      check_bit("stop2 start seen", t < 200, 1'b1);
      t = 0;
      while (tx_s2 !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
      check_bit("stop2 stop seen", t < 2000, 1'b1);
      n = 0;
      while (donetx_s2 !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      check_val("stop2 high cycles", 32'(n), 32'd192);
      check_bit("stop2 tx at donetx", tx_s2, 1'b1);
      check_bit("stop2 busy at donetx", txbusy_s2, 1'b0);

      // framing error on 0x3C, then line held low
      loop_en = 1'b0;
      repeat (200) @(negedge clk);
      r0 = drx_cnt[0];
      drive_rx(0, 12'h078, 10, 1'b0);
      repeat (20) @(negedge clk);
      check_val("ferr count", 32'(drx_cnt[0] - r0), 32'd1);
      check_val("ferr data", 32'(cap_data[0]), 32'h3C);
      check_bit("ferr flag", cap_ferr[0], 1'b1);
      check_bit("ferr perr", cap_perr[0], 1'b0);
      r0 = drx_cnt[0];
      repeat (12 * BIT) @(negedge clk);
      check_val("break hold count", 32'(drx_cnt[0] - r0), 32'd0);
      check_bit("break hold ferr", ferr_m, 1'b1);
      rx_drv = 1'b1;
      repeat (200) @(negedge clk);
      r0 = drx_cnt[0];
      drive_rx(0, 12'h2AA, 10, 1'b1);
      repeat (BIT) @(negedge clk);
      check_val("after break count", 32'(drx_cnt[0] - r0), 32'd1);
      check_val("after break data", 32'(cap_data[0]), 32'h55);
      check_bit("after break ferr", cap_ferr[0], 1'b0);

      // short low glitch of 3*DIV cycles
      r0 = drx_cnt[0];
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (18) @(negedge clk);
      rx_drv = 1'b1;
      repeat (400) @(negedge clk);
      check_val("glitch count", 32'(drx_cnt[0] - r0), 32'd0);
      check_val("glitch doutrx", 32'(doutrx_m), 32'h55);
      check_bit("glitch ferr", ferr_m, 1'b0);
      check_bit("glitch perr", perr_m, 1'b0);

      // reset in the middle of the data bits, TX and RX both busy
      loop_en = 1'b1;
      repeat (200) @(negedge clk);
      dintx_m = 8'h00; newd_m = 1'b1;
      @(negedge clk);
      newd_m = 1'b0;
      t = 0;
      while (tx_m !== 1'b0 && t < 200) begin @(negedge clk); t++; end
      check_bit("midrst start seen", t < 200, 1'b1);
      repeat (BIT / 2 + 3 * BIT) @(negedge clk);
      check_bit("midrst tx in data", tx_m, 1'b0);
      rst = 1'b0;
      #1;
      check_bit("midrst tx", tx_m, 1'b1);
      check_bit("midrst txbusy", txbusy_m, 1'b0);
      check_val("midrst doutrx", 32'(doutrx_m), 32'h0);
      check_bit("midrst donerx", donerx_m, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      r0 = drx_cnt[0];
      send_frame(0, 8'hA5, 12'h34A, 10, "post reset");
      check_val("post reset donerx count", 32'(drx_cnt[0] - r0), 32'd1);
      check_val("post reset doutrx", 32'(cap_data[0]), 32'hA5);
      check_bit("post reset ferr", cap_ferr[0], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
